// File: rtl/gate_mux_pkg.sv
// gate_mux_pkg
// Definitions shared by the mux-built gate cell and the scheduler that owns it.
// - OP_NOT..OP_XNOR, OP_ILL : 3-bit gate op codes carried with each request
// - state_t                 : scheduler FSM encoding (IDLE / SHIFT / DONE)
// - op_is_illegal()         : true for the one op code the cell cannot evaluate
package gate_mux_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op == OP_ILL);
  endfunction

endpackage

// File: rtl/mux2x1.sv
// mux2x1
// Basic 2:1 multiplexer, the only primitive the gate cell is built from.
// - s  : select
// - d0 : output when s=0
// - d1 : output when s=1
// - y  : selected data
module mux2x1 (
  input  logic s,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_gate_cell.sv
// mux_gate_cell
// Combinational 1-bit logic cell. Every gate is realised as a 2:1 mux whose
// select is operand a; the op code then picks which mux output is used.
// - op  : gate op code (see gate_mux_pkg)
// - a   : operand bit a (drives every mux select)
// - b   : operand bit b
// - y   : gate result, forced to 0 for the illegal op
// - ill : high when op is the illegal code
module mux_gate_cell
  import gate_mux_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y,
  output logic       ill
);

  logic       nb;
  logic [6:0] cand;

  assign nb = ~b;

  // One mux per op, indexed by op code. With a as select:
  // NOT b  -> both legs ~b (a ignored)
  // OR     -> a ? 1 : b          AND  -> a ? b  : 0
  // NAND   -> a ? ~b : 1         NOR  -> a ? 0  : ~b
  // XOR    -> a ? ~b : b         XNOR -> a ? b  : ~b
  mux2x1 u_not  (.s(a), .d0(nb),   .d1(nb),   .y(cand[0]));
  mux2x1 u_or   (.s(a), .d0(b),    .d1(1'b1), .y(cand[1]));
  mux2x1 u_and  (.s(a), .d0(1'b0), .d1(b),    .y(cand[2]));
  mux2x1 u_nand (.s(a), .d0(1'b1), .d1(nb),   .y(cand[3]));
  mux2x1 u_nor  (.s(a), .d0(nb),   .d1(1'b0), .y(cand[4]));
  mux2x1 u_xor  (.s(a), .d0(b),    .d1(nb),   .y(cand[5]));
  mux2x1 u_xnor (.s(a), .d0(nb),   .d1(b),    .y(cand[6]));

  assign ill = op_is_illegal(op);

  // Pick the mux belonging to the requested op; the illegal op yields 0.
  always_comb begin
    y = 1'b0;
    case (op)
      OP_NOT:  y = cand[0];
      OP_OR:   y = cand[1];
      OP_AND:  y = cand[2];
      OP_NAND: y = cand[3];
      OP_NOR:  y = cand[4];
      OP_XOR:  y = cand[5];
      OP_XNOR: y = cand[6];
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_gate_scheduler.sv
// mux_gate_scheduler
// Shares one bit-serial mux_gate_cell among NREQ requesters. A round-robin
// arbiter accepts one request, the operands are fed LSB-first through the cell
// over W cycles, and the result is offered on a valid/ready response channel
// tagged with the requester id.
// - clk, rst  : clock (rising edge), asynchronous active-high reset
// - req_valid : per-requester request pending
// - req_ready : one-hot accept strobe, only ever high in IDLE
// - req_op    : 3-bit op per requester, slice i = [3i+2:3i]
// - req_a/b   : W-bit operands per requester, slice i = [Wi+W-1:Wi]
// - rsp_valid : result held for the consumer
// - rsp_ready : consumer takes the result
// - rsp_id    : requester that owns rsp_data
// - rsp_data  : result word
// - rsp_err   : op was illegal, rsp_data is 0
// - busy      : FSM not in IDLE
module mux_gate_scheduler
  import gate_mux_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  // Extra counter bit keeps W=1 and power-of-two W from overflowing.
  localparam int CW  = $clog2(W) + 1;
  localparam int IW1 = IDW + 1;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           accept;
  logic [2:0]     sel_op;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic [IDW-1:0] id_q;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           err_q;
  logic [W-1:0]   res;
  logic [CW-1:0]  cnt;
  logic           last_bit;
  logic           cell_y;
  logic           cell_ill;
  logic           res_bit;

  // Round-robin search: scan from rr_ptr upward with wrap, first set bit
  // wins. The index is formed one bit wider so non-power-of-two NREQ wraps.
  always_comb begin
    logic [IW1-1:0] sum;
    logic [IDW-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + IW1'(i);
      if (sum >= IW1'(NREQ)) begin
        sum = sum - IW1'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Route the winner's op and operands to the capture registers.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[W*i +: W];
        sel_b  = req_b[W*i +: W];
      end
    end
  end

  // The operands are shifted right every SHIFT cycle, so bit 0 is always
  // the a[cnt]/b[cnt] pair the cell should see in that cycle.
  mux_gate_cell u_cell (
    .op  (op_q),
    .a   (a_q[0]),
    .b   (b_q[0]),
    .y   (cell_y),
    .ill (cell_ill)
  );

  assign res_bit  = cell_y & ~cell_ill;
  assign last_bit = (cnt == CW'(W - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and accept strobe. req_ready is raised only in IDLE, so a
  // request can never be taken in the cycle of a response handshake.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          accept               = 1'b1;
          req_ready[grant_idx] = 1'b1;
          state_nxt            = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, bit-serial evaluation and round-robin pointer. cnt
  // stops at W-1 so it always names the result bit currently being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      id_q   <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      err_q  <= 1'b0;
      res    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      id_q   <= grant_idx;
      op_q   <= sel_op;
      a_q    <= sel_a;
      b_q    <= sel_b;
      err_q  <= op_is_illegal(sel_op);
      res    <= '0;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
      res <= res | (W'(res_bit) << cnt);
      if (!last_bit) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_id    = id_q;
  assign rsp_data  = res;
  assign rsp_err   = err_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mux_gate_scheduler.sv
// tb_mux_gate_scheduler
// Directed bench for mux_gate_scheduler (NREQ=4, W=8): reset values, single
// request latency, every op code, round-robin order, backpressure and an
// abort by reset in the middle of a transaction.
module tb_mux_gate_scheduler;
  import gate_mux_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;

  int checks = 0;
  int passed = 0;

  mux_gate_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design locks up somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy);
    req_valid = valid;
    rsp_ready = rdy;
    #1;
  endtask

  task automatic setReq(input int id, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[3*id +: 3] = op;
    req_a[W*id +: W]  = a;
    req_b[W*id +: W]  = b;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(0));
    checkOutput({tag, ".rsp_id"},    32'(rsp_id),    32'(0));
    checkOutput({tag, ".rsp_data"},  32'(rsp_data),  32'(0));
    checkOutput({tag, ".rsp_err"},   32'(rsp_err),   32'(0));
    checkOutput({tag, ".busy"},      32'(busy),      32'(0));
    checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'(0));
  endtask

  // Full transaction with rsp_ready high: grant, W+1 cycle latency, response
  // contents, then the return to IDLE one cycle after the handshake.
  task automatic serve(input string tag, input logic [NREQ-1:0] mask,
                       input int exp_id, input logic [W-1:0] exp_data,
                       input logic exp_err);
    int lat;
    applyStimulus(mask, 1'b1);
    checkOutput({tag, ".grant"}, 32'(req_ready), 32'(1) << exp_id);
    step();
    lat = 1;
    checkOutput({tag, ".ready_shift"}, 32'(req_ready), 32'(0));
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    checkOutput({tag, ".latency"},  32'(lat),      32'(W + 1));
    checkOutput({tag, ".rsp_id"},   32'(rsp_id),   32'(exp_id));
    checkOutput({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
    checkOutput({tag, ".rsp_err"},  32'(rsp_err),  32'(exp_err));
    checkOutput({tag, ".busy"},     32'(busy),     32'(1));
    step();
    checkOutput({tag, ".valid_drop"}, 32'(rsp_valid), 32'(0));
    checkOutput({tag, ".idle"},       32'(busy),      32'(0));
  endtask

  initial begin
    logic [W-1:0] exp_ops [8];
    int waited;
    exp_ops = '{8'h59, 8'hEE, 8'h82, 8'h7D, 8'h11, 8'h6C, 8'h93, 8'h00};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    step();

    // Single request from requester 2: F0 & 3C = 30.
    setReq(2, OP_AND, 8'hF0, 8'h3C);
    serve("single", 4'b0100, 2, 8'h30, 1'b0);
    applyStimulus(4'b0000, 1'b1);

    // Every op code with a=CA, b=A6 from requester 1.
    for (int op = 0; op < 8; op++) begin
      setReq(1, 3'(op), 8'hCA, 8'hA6);
      serve($sformatf("op%0d", op), 4'b0010, 1, exp_ops[op], (op == 7));
    end
    applyStimulus(4'b0000, 1'b1);

    // Fairness from a fresh pointer: all requesters valid, data = 50 | id.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < NREQ; i++) begin
      setReq(i, OP_OR, 8'(i), 8'h50);
    end
    for (int i = 0; i < NREQ; i++) begin
      serve($sformatf("fair%0d", i), 4'b1111, i, 8'h50 | 8'(i), 1'b0);
    end
    serve("fair_wrap0", 4'b1001, 0, 8'h50, 1'b0);
    serve("fair_wrap3", 4'b1001, 3, 8'h53, 1'b0);

    // Backpressure: requester 1 XOR, response held for 20 cycles.
    setReq(1, OP_XOR, 8'hCA, 8'hA6);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("bp.grant", 32'(req_ready), 32'(4'b0010));
    step();
    applyStimulus(4'b1111, 1'b0);
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      step();
      waited++;
    end
    checkOutput("bp.arrive", 32'(rsp_valid), 32'(1));
    for (int c = 0; c < 20; c++) begin
      checkOutput("bp.rsp_valid", 32'(rsp_valid), 32'(1));
      checkOutput("bp.rsp_id",    32'(rsp_id),    32'(1));
      checkOutput("bp.rsp_data",  32'(rsp_data),  32'(8'h6C));
      checkOutput("bp.req_ready", 32'(req_ready), 32'(0));
      checkOutput("bp.busy",      32'(busy),      32'(1));
      step();
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("bp.hs_valid", 32'(rsp_valid), 32'(1));
    step();
    checkOutput("bp.after_valid", 32'(rsp_valid), 32'(0));
    checkOutput("bp.after_busy",  32'(busy),      32'(0));
    step();
    checkOutput("bp.stay_idle", 32'(busy), 32'(0));

    // Reset while SHIFT is at cnt=3: accept edge leaves cnt=0, three more
    // edges bring it to 3, then reset aborts the transaction.
    setReq(2, OP_XOR, 8'hFF, 8'h00);
    applyStimulus(4'b0100, 1'b1);
    step();
    applyStimulus(4'b0000, 1'b1);
    step();
    step();
    step();
    checkOutput("abort.busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkResetOutputs("abort");
    for (int i = 0; i < NREQ; i++) begin
      setReq(i, OP_OR, 8'(i), 8'h50);
    end
    serve("post_reset", 4'b1111, 0, 8'h50, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
